// File: rtl/instr_encoder.sv
// RV32I instruction assembler: symbolic request -> encoded word, with legality
// check, reject signalling, saturating counters and a DEPTH-entry output FIFO.
module instr_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             err,
    output logic [CNT_W-1:0] emit_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LD   = 7'b0000011;
    localparam logic [6:0] OPC_ST   = 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_t;

    enc_t               enc;
    logic signed [31:0] simm;
    logic               fits12, fits_b, fits_j, fits_sh;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   mem [DEPTH];
    logic          accept, push, pop;

    assign simm    = in_imm;
    assign fits12  = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    assign fits_b  = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !in_imm[0];
    assign fits_j  = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !in_imm[0];
    assign fits_sh = (in_imm[31:5] == 27'd0);

    // Unused register fields are left at zero by construction of each format.
    always_comb begin
        enc.legal = 1'b1;
        enc.word  = '0;
        case (in_op)
            5'd0:  enc.word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
            5'd1:  enc.word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
            5'd2:  enc.word = {7'b0000000, in_rs2, in_rs1, 3'b100, in_rd, OPC_R};
            5'd3:  enc.word = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OPC_R};
            5'd4:  enc.word = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OPC_R};
            5'd5:  begin enc.legal = fits12; enc.word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_I}; end
            5'd6:  begin enc.legal = fits12; enc.word = {in_imm[11:0], in_rs1, 3'b100, in_rd, OPC_I}; end
            5'd7:  begin enc.legal = fits12; enc.word = {in_imm[11:0], in_rs1, 3'b110, in_rd, OPC_I}; end
            5'd8:  begin enc.legal = fits12; enc.word = {in_imm[11:0], in_rs1, 3'b111, in_rd, OPC_I}; end
            5'd9:  begin enc.legal = fits_sh; enc.word = {7'b0, in_imm[4:0], in_rs1, 3'b001, in_rd, OPC_I}; end
            5'd10: begin enc.legal = fits_sh; enc.word = {7'b0, in_imm[4:0], in_rs1, 3'b101, in_rd, OPC_I}; end
            5'd11: begin enc.legal = fits12; enc.word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_I}; end
            5'd12: begin enc.legal = fits12; enc.word = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LD}; end
            5'd13: begin enc.legal = fits12; enc.word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_LD}; end
            5'd14: begin enc.legal = fits12; enc.word = {in_imm[11:0], in_rs1, 3'b001, in_rd, OPC_LD}; end
            5'd15: begin enc.legal = fits12; enc.word = {in_imm[11:0], in_rs1, 3'b100, in_rd, OPC_LD}; end
            5'd16: begin
                enc.legal = fits12;
                enc.word  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_ST};
            end
            5'd17: begin
                enc.legal = fits_b;
                enc.word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                             in_imm[4:1], in_imm[11], OPC_BR};
            end
            5'd18: begin
                enc.legal = fits_j;
                enc.word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
            end
            5'd19: begin enc.legal = fits12; enc.word = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR}; end
            default: enc.legal = 1'b0;
        endcase
    end

    // in_ready depends only on FIFO occupancy (and reset), never on out_ready.
    assign in_ready  = rst_n && (count < FULL);
    assign out_valid = (count != '0);
    assign out_instr = out_valid ? mem[rd_ptr] : 32'h0;
    assign accept    = in_valid && in_ready;
    assign push      = accept && enc.legal;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc.word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err      <= 1'b0;
            emit_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            err <= accept && !enc.legal;
            if (push && !(&emit_cnt)) emit_cnt <= emit_cnt + 1'b1;
            if (accept && !enc.legal && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised + directed bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, err;
    logic [4:0]  in_op, in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, out_instr;
    logic [15:0] emit_cnt, err_cnt;

    logic        s_valid, s_ready, s_out_valid, s_err;
    logic [31:0] s_instr;
    logic [2:0]  s_emit, s_errc;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    int          m_emit, m_err;
    bit          m_err_pulse;

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .err(err), .emit_cnt(emit_cnt), .err_cnt(err_cnt)
    );

    instr_encoder #(.DEPTH(4), .CNT_W(3)) sat_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(s_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(s_out_valid), .out_ready(1'b1), .out_instr(s_instr),
        .err(s_err), .emit_cnt(s_emit), .err_cnt(s_errc)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Reference encoder built from the instruction-format field positions.
    function automatic void ref_enc(input int op, input int rd, input int rs1, input int rs2,
                                    input int imm, output bit legal, output logic [31:0] w);
        logic [31:0] u;
        bit i12;
        int f3;
        u = imm;
        i12 = (imm >= -2048) && (imm <= 2047);
        legal = 1;
        w = 0;
        f3 = 0;
        if (op <= 4) begin
            case (op) 2: f3 = 4; 3: f3 = 6; 4: f3 = 7; default: f3 = 0; endcase
            w = ((op == 1 ? 32 : 0) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
        end else if (op <= 11) begin
            case (op) 6: f3 = 4; 7: f3 = 6; 8: f3 = 7; 9: f3 = 1; 10: f3 = 5; 11: f3 = 2; default: f3 = 0; endcase
            if (op == 9 || op == 10) begin
                legal = (imm >= 0) && (imm <= 31);
                w = ((u & 'h1f) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
            end else begin
                legal = i12;
                w = ((u & 'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
            end
        end else if (op <= 15) begin
            case (op) 12: f3 = 2; 13: f3 = 0; 14: f3 = 1; default: f3 = 4; endcase
            legal = i12;
            w = ((u & 'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h03;
        end else if (op == 16) begin
            legal = i12;
            w = (((u >> 5) & 'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) | ((u & 'h1f) << 7) | 'h23;
        end else if (op == 17) begin
            legal = (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
            w = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3f) << 25) | (rs2 << 20) | (rs1 << 15)
              | (((u >> 1) & 'hf) << 8) | (((u >> 11) & 1) << 7) | 'h63;
        end else if (op == 18) begin
            legal = (imm >= -1048576) && (imm <= 1048574) && (imm % 2 == 0);
            w = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3ff) << 21) | (((u >> 11) & 1) << 20)
              | (((u >> 12) & 'hff) << 12) | (rd << 7) | 'h6f;
        end else if (op == 19) begin
            legal = i12;
            w = ((u & 'hfff) << 20) | (rs1 << 15) | (rd << 7) | 'h67;
        end else begin
            legal = 0;
        end
    endfunction

    task automatic set_req(input int op, input int rd, input int rs1, input int rs2, input int imm);
        in_op = 5'(op); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_imm = imm;
    endtask

    // One clock of stimulus, entered and left at the falling edge; updates the model only.
    task automatic drive_cycle(input bit v, input bit rdy, output bit acc);
        bit legal;
        bit popped;
        logic [31:0] w;
        in_valid = v;
        out_ready = rdy;
        acc = v && (exp_q.size() < 2);
        popped = rdy && (exp_q.size() != 0);
        ref_enc(int'(in_op), int'(in_rd), int'(in_rs1), int'(in_rs2), int'(in_imm), legal, w);
        @(posedge clk);
        if (popped) void'(exp_q.pop_front());
        m_err_pulse = acc && !legal;
        if (acc && legal) begin
            exp_q.push_back(w);
            if (m_emit < 65535) m_emit++;
        end
        if (acc && !legal && m_err < 65535) m_err++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 0; s_valid = 0; out_ready = 0;
        rst_n = 0;
        exp_q.delete();
        m_emit = 0; m_err = 0; m_err_pulse = 0;
        #2;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 0; s_valid = 0; out_ready = 0;
        set_req(0, 0, 0, 0, 0);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready act=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0) begin failures++; $display("FAIL rst_out act=%b/%h exp=0/0", out_valid, out_instr); end
        checks++; if (err !== 1'b0 || emit_cnt !== 16'h0 || err_cnt !== 16'h0) begin failures++; $display("FAIL rst_cnt act=%b/%h/%h exp=0/0/0", err, emit_cnt, err_cnt); end
        do_reset();
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rel_in_ready act=%b exp=1", in_ready); end
    endtask

    task automatic test_addi();
        bit acc;
        do_reset();
        set_req(5, 1, 0, 0, 5);
        drive_cycle(1, 1, acc);
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h00500093) begin failures++; $display("FAIL addi_word act=%b/%h exp=1/00500093", out_valid, out_instr); end
        checks++; if (emit_cnt !== 16'd1 || err !== 1'b0) begin failures++; $display("FAIL addi_cnt act=%0d/%b exp=1/0", emit_cnt, err); end
        drive_cycle(0, 1, acc);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL addi_drain act=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] k [4];
        bit acc;
        k[0] = 32'h002081B3; k[1] = 32'h0020A423; k[2] = 32'h00208463; k[3] = 32'h010000EF;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_req(0, 3, 1, 2, 0);
                1: set_req(16, 0, 1, 2, 8);
                2: set_req(17, 0, 1, 2, 8);
                default: set_req(18, 1, 0, 0, 16);
            endcase
            drive_cycle(1, 1, acc);
            checks++; if (out_valid !== 1'b1 || out_instr !== k[i]) begin failures++; $display("FAIL b2b_%0d act=%b/%h exp=1/%h", i, out_valid, out_instr, k[i]); end
        end
        checks++; if (emit_cnt !== 16'd4) begin failures++; $display("FAIL b2b_emit act=%0d exp=4", emit_cnt); end
        drive_cycle(0, 1, acc);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain act=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] k [3];
        logic [31:0] seen [$];
        bit acc;
        int sent;
        k[0] = 32'h00100093; k[1] = 32'h00200113; k[2] = 32'h00300193;
        do_reset();
        sent = 0;
        for (int c = 0; c < 3; c++) begin
            set_req(5, sent + 1, 0, 0, sent + 1);
            drive_cycle(1, 0, acc);
            if (acc) sent++;
            checks++; if (out_instr !== k[0]) begin failures++; $display("FAIL bp_head act=%h exp=%h", out_instr, k[0]); end
        end
        checks++; if (sent != 2 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_full act=%0d/%b exp=2/0", sent, in_ready); end
        for (int c = 0; c < 6; c++) begin
            if (out_valid) seen.push_back(out_instr);
            set_req(5, sent + 1, 0, 0, sent + 1);
            drive_cycle(sent < 3, 1, acc);
            if (c == 0) begin
                checks++; if (acc !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_third act=%b/%b exp=0/1", acc, in_ready); end
            end
            if (acc) sent++;
        end
        checks++; if (seen.size() != 3) begin failures++; $display("FAIL bp_count act=%0d exp=3", seen.size()); end
        for (int i = 0; i < 3 && i < seen.size(); i++) begin
            checks++; if (seen[i] !== k[i]) begin failures++; $display("FAIL bp_order_%0d act=%h exp=%h", i, seen[i], k[i]); end
        end
    endtask

    task automatic test_illegal();
        bit acc;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: set_req(5, 1, 0, 0, 2048);
                1: set_req(17, 0, 1, 2, 7);
                default: set_req(25, 1, 1, 1, 0);
            endcase
            drive_cycle(1, 1, acc);
            checks++; if (err !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL ill_%0d act=%b/%b exp=1/0", i, err, out_valid); end
            drive_cycle(0, 1, acc);
            checks++; if (err !== 1'b0) begin failures++; $display("FAIL ill_pulse_%0d act=%b exp=0", i, err); end
        end
        checks++; if (err_cnt !== 16'd3 || emit_cnt !== 16'd0) begin failures++; $display("FAIL ill_cnt act=%0d/%0d exp=3/0", err_cnt, emit_cnt); end
        set_req(17, 0, 1, 2, 6);
        drive_cycle(1, 1, acc);
        checks++; if (err !== 1'b0 || out_instr !== 32'h00208363) begin failures++; $display("FAIL beq6 act=%b/%h exp=0/00208363", err, out_instr); end
        drive_cycle(0, 1, acc);
    endtask

    function automatic int rand_imm();
        case ($urandom_range(0, 4))
            0: return int'($urandom_range(0, 63)) - 32;
            1: case ($urandom_range(0, 11))
                   0: return -2048;  1: return 2047;    2: return 2048;     3: return -2049;
                   4: return -4096;  5: return 4094;    6: return 4095;     7: return -4097;
                   8: return -1048576; 9: return 1048574; 10: return 1048576; default: return 32;
               endcase
            2: return int'($urandom);
            3: return int'($urandom_range(0, 8191)) - 4096;
            default: return int'($urandom_range(0, 4194303)) - 2097152;
        endcase
    endfunction

    task automatic test_random();
        bit acc;
        logic [31:0] eh;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            set_req(int'($urandom_range(0, 22)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), rand_imm());
            drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, acc);
            eh = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
            checks++; if (out_valid !== (exp_q.size() != 0) || out_instr !== eh) begin failures++; $display("FAIL rnd_out c=%0d act=%b/%h exp=%b/%h", c, out_valid, out_instr, exp_q.size() != 0, eh); end
            checks++; if (in_ready !== (exp_q.size() < 2)) begin failures++; $display("FAIL rnd_ready c=%0d act=%b exp=%b", c, in_ready, exp_q.size() < 2); end
            checks++; if (err !== m_err_pulse) begin failures++; $display("FAIL rnd_err c=%0d act=%b exp=%b", c, err, m_err_pulse); end
            checks++; if (emit_cnt !== 16'(m_emit) || err_cnt !== 16'(m_err)) begin failures++; $display("FAIL rnd_cnt c=%0d act=%0d/%0d exp=%0d/%0d", c, emit_cnt, err_cnt, m_emit, m_err); end
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        do_reset();
        set_req(5, 1, 0, 0, 5);
        drive_cycle(1, 0, acc);
        drive_cycle(1, 0, acc);
        in_valid = 0;
        #2 rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst act=%b/%h/%b exp=0/0/0", out_valid, out_instr, in_ready); end
        checks++; if (emit_cnt !== 16'h0 || err_cnt !== 16'h0) begin failures++; $display("FAIL mid_cnt act=%0d/%0d exp=0/0", emit_cnt, err_cnt); end
        do_reset();
        set_req(0, 3, 1, 2, 0);
        drive_cycle(1, 1, acc);
        checks++; if (out_instr !== 32'h002081B3 || emit_cnt !== 16'd1) begin failures++; $display("FAIL mid_resume act=%h/%0d exp=002081b3/1", out_instr, emit_cnt); end
        drive_cycle(0, 1, acc);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            set_req(5, 1, 0, 0, k);
            s_valid = 1;
            @(posedge clk); @(negedge clk);
            checks++; if (s_emit !== 3'((k > 7) ? 7 : k) || s_instr !== (32'(k) << 20 | 32'h93)) begin failures++; $display("FAIL sat_emit k=%0d act=%0d/%h exp=%0d", k, s_emit, s_instr, (k > 7) ? 7 : k); end
        end
        for (int k = 1; k <= 10; k++) begin
            set_req(5, 1, 0, 0, 5000);
            @(posedge clk); @(negedge clk);
            checks++; if (s_errc !== 3'((k > 7) ? 7 : k) || s_emit !== 3'd7) begin failures++; $display("FAIL sat_err k=%0d act=%0d/%0d exp=%0d/7", k, s_errc, s_emit, (k > 7) ? 7 : k); end
        end
        s_valid = 0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
